// File: rtl/pe_acc_requant_if.sv
// Handshake bundle for pe_acc_requant: the accumulator input beat with its
// per-beat requantisation settings, and the packed int8 output stream.
interface pe_acc_requant_if #(
    parameter int ACC_IN_W = 64,
    parameter int OUT_W    = 32
);
    logic                acc_valid;
    logic                acc_ready;
    logic [ACC_IN_W-1:0] acc_in;
    logic                mode;
    logic [ACC_IN_W-1:0] bias;
    logic [4:0]          shift;
    logic                relu;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_W-1:0]    out_data;

    // master is the surrounding PE: it produces accumulator beats and consumes results
    modport master (
        output acc_valid, acc_in, mode, bias, shift, relu, out_ready,
        input  acc_ready, out_valid, out_data
    );

    modport slave (
        input  acc_valid, acc_in, mode, bias, shift, relu, out_ready,
        output acc_ready, out_valid, out_data
    );
endinterface

// File: rtl/pe_acc_requant.sv
// Accumulator drain stage: bias add, rounding arithmetic shift, int8 saturation.
// Optional ReLU clamp is built only when REQUANT_RELU_EN is defined.
module pe_acc_requant #(
    parameter int ACC_W88  = 24,
    parameter int ACC_W18  = 16,
    parameter int ACC_IN_W = 64,
    parameter int OUT_W    = 32
) (
    input  logic            clk,
    input  logic            reset,
    pe_acc_requant_if.slave bus,
    input  logic            stat_clr,
    output logic [15:0]     sat_count
);
    localparam int         LANES     = 4;
    localparam int         BIAS_W    = 16;
    localparam int         SUM_W     = 27;
    localparam int         RND_W     = 28;
    localparam logic [4:0] SHIFT_MAX = 5'd25;

    logic [ACC_IN_W-1:0] acc_word;
    logic                stall;
    logic [4:0]          shift_sat;

    logic                s1_valid_reg;
    logic                s1_mode_reg;
    logic [4:0]          s1_shift_reg;
    logic                s2_valid_reg;
    logic                s2_mode_reg;
    logic                s2_relu_eff;

    logic                out_valid_reg;
    logic [OUT_W-1:0]    out_data_reg;
    logic [15:0]         sat_count_reg;

    logic [OUT_W-1:0]    lane_byte;
    logic [LANES-1:0]    lane_sat;
    logic [2:0]          sat_inc;
    logic [16:0]         sat_sum;
    logic [15:0]         sat_next;

    assign acc_word  = bus.acc_in;
    // Single global stall: nothing moves while the output word is held
    assign stall         = out_valid_reg && !bus.out_ready;
    assign bus.acc_ready = !stall;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign sat_count     = sat_count_reg;

    assign shift_sat = (bus.shift > SHIFT_MAX) ? SHIFT_MAX : bus.shift;

`ifdef REQUANT_RELU_EN
    logic s1_relu_reg;
    logic s2_relu_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_relu_reg <= 1'b0;
            s2_relu_reg <= 1'b0;
        end else if (!stall) begin
            s1_relu_reg <= bus.relu;
            s2_relu_reg <= s1_relu_reg;
        end
    end

    assign s2_relu_eff = s2_relu_reg;
`else
    logic unused_relu;
    assign unused_relu = bus.relu;
    assign s2_relu_eff = 1'b0;
`endif

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam bit IN_MODE0 = (gi < 2);

        logic signed [SUM_W-1:0] narrow_ext;
        logic signed [SUM_W-1:0] wide_ext;
        logic signed [SUM_W-1:0] lane_ext;
        logic signed [SUM_W-1:0] bias_ext;
        logic signed [SUM_W-1:0] s1_sum_next;
        logic signed [SUM_W-1:0] s1_sum_reg;
        logic        [RND_W-1:0] rnd;
        logic signed [RND_W-1:0] rounded;
        logic signed [RND_W-1:0] s2_val_next;
        logic signed [RND_W-1:0] s2_val_reg;
        logic                    s3_active;
        logic                    s3_hi;
        logic                    s3_lo;
        logic                    s3_neg_clamp;
        logic        [7:0]       s3_byte;

        // S1: sign-extend lane and bias to a common width and add
        assign narrow_ext = {{(SUM_W-ACC_W18){acc_word[gi*ACC_W18+ACC_W18-1]}},
                             acc_word[gi*ACC_W18 +: ACC_W18]};
        if (IN_MODE0) begin : g_wide
            assign wide_ext = {{(SUM_W-ACC_W88){acc_word[gi*ACC_W88+ACC_W88-1]}},
                               acc_word[gi*ACC_W88 +: ACC_W88]};
        end else begin : g_no_wide
            assign wide_ext = '0;
        end
        assign lane_ext    = bus.mode ? narrow_ext : wide_ext;
        assign bias_ext    = {{(SUM_W-BIAS_W){bus.bias[gi*BIAS_W+BIAS_W-1]}},
                              bus.bias[gi*BIAS_W +: BIAS_W]};
        assign s1_sum_next = lane_ext + bias_ext;

        // S2: add half an LSB of the result, then arithmetic shift (round half up)
        assign rnd         = (s1_shift_reg == 5'd0) ? '0 : (RND_W'(1) << (s1_shift_reg - 5'd1));
        assign rounded     = $signed({s1_sum_reg[SUM_W-1], s1_sum_reg}) + $signed(rnd);
        assign s2_val_next = rounded >>> s1_shift_reg;

        // S3: clamp to int8; a ReLU-zeroed value is not a saturation event
        assign s3_active    = s2_mode_reg || IN_MODE0;
        assign s3_hi        = s2_val_reg > 28'sd127;
        assign s3_lo        = s2_val_reg < -28'sd128;
        assign s3_neg_clamp = s2_relu_eff && s2_val_reg[RND_W-1];

        always_comb begin
            s3_byte = s2_val_reg[7:0];
            if (!s3_active || s3_neg_clamp) begin
                s3_byte = 8'h00;
            end else if (s3_hi) begin
                s3_byte = 8'h7F;
            end else if (s3_lo) begin
                s3_byte = 8'h80;
            end
        end

        assign lane_byte[gi*8 +: 8] = s3_byte;
        assign lane_sat[gi]         = s3_active && !s3_neg_clamp && (s3_hi || s3_lo);

        always_ff @(posedge clk) begin
            if (reset) begin
                s1_sum_reg <= '0;
                s2_val_reg <= '0;
            end else if (!stall) begin
                s1_sum_reg <= s1_sum_next;
                s2_val_reg <= s2_val_next;
            end
        end
    end

    always_comb begin
        sat_inc = '0;
        for (int i = 0; i < LANES; i++) begin
            sat_inc = sat_inc + {2'b00, lane_sat[i]};
        end
    end

    assign sat_sum  = {1'b0, sat_count_reg} + {14'b0, sat_inc};
    assign sat_next = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg  <= 1'b0;
            s1_mode_reg   <= 1'b0;
            s1_shift_reg  <= '0;
            s2_valid_reg  <= 1'b0;
            s2_mode_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            sat_count_reg <= '0;
        end else begin
            if (!stall) begin
                s1_valid_reg  <= bus.acc_valid;
                s1_mode_reg   <= bus.mode;
                s1_shift_reg  <= shift_sat;
                s2_valid_reg  <= s1_valid_reg;
                s2_mode_reg   <= s1_mode_reg;
                out_valid_reg <= s2_valid_reg;
                out_data_reg  <= s2_valid_reg ? lane_byte : '0;
            end
            if (stat_clr) begin
                sat_count_reg <= '0;
            end else if (!stall && s2_valid_reg) begin
                sat_count_reg <= sat_next;
            end
        end
    end
endmodule

// File: tb/tb_pe_acc_requant.sv
// Bench for pe_acc_requant: directed vector table, stall/reset/counter sequences,
// and a randomized stream scored against an integer reference model.
module tb_pe_acc_requant;
    logic        clk = 1'b0;
    logic        reset;
    logic        stat_clr;
    logic [15:0] sat_count;

    always #5 clk = ~clk;

    pe_acc_requant_if bus ();

    pe_acc_requant dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .stat_clr  (stat_clr),
        .sat_count (sat_count)
    );

`ifdef REQUANT_RELU_EN
    localparam bit RELU_BUILT = 1'b1;
`else
    localparam bit RELU_BUILT = 1'b0;
`endif

    typedef struct {
        logic        mode;
        logic [63:0] acc;
        logic [63:0] bias;
        logic [4:0]  shift;
        logic        relu;
        logic [31:0] exp_data;
        int          exp_sat_inc;
        logic        clr_after;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          nsat;
    } exp_t;

    localparam int NV = 8;
    vec_t vec [NV];
    exp_t exp_q [$];

    int   checks = 0;
    int   errors = 0;
    int   exp_sat = 0;
    int   n_out = 0;
    int   stall_cycles = 0;
    bit   quiet = 1'b0;
    bit   stall_prev = 1'b0;
    logic [31:0] data_prev = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=completion", name);
    endtask

    // Reference: plain integer arithmetic on each active lane
    function automatic void ref_beat(input logic m, input logic [63:0] acc, input logic [63:0] b,
                                     input logic [4:0] sh_in, input logic rl,
                                     output logic [31:0] data, output int nsat);
        int v;
        int sh;
        data = '0;
        nsat = 0;
        sh = (sh_in > 5'd25) ? 25 : int'(sh_in);
        for (int i = 0; i < 4; i++) begin
            if (!m && i >= 2) continue;
            if (m) v = int'($signed(acc[16*i +: 16]));
            else   v = int'($signed(acc[24*i +: 24]));
            v = v + int'($signed(b[16*i +: 16]));
            if (sh > 0) v = v + (1 << (sh - 1));
            v = v >>> sh;
            if (RELU_BUILT && rl && v < 0) v = 0;
            if (v > 127) begin
                v = 127;
                nsat++;
            end else if (v < -128) begin
                v = -128;
                nsat++;
            end
            data[8*i +: 8] = v[7:0];
        end
    endfunction

    // Scoreboard and stall checks, sampled mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
            exp_sat = 0;
            stall_prev = 1'b0;
        end else begin
            if (bus.out_valid && !bus.out_ready) begin
                stall_cycles++;
                check("stall_acc_ready", {63'b0, bus.acc_ready}, 64'd0);
                if (stall_prev) check("stall_hold", {32'b0, bus.out_data}, {32'b0, data_prev});
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            data_prev  = bus.out_data;
            if (bus.acc_valid && bus.acc_ready) begin
                ref_beat(bus.mode, bus.acc_in, bus.bias, bus.shift, bus.relu, e.data, e.nsat);
                exp_q.push_back(e);
                exp_sat = (exp_sat + e.nsat > 65535) ? 65535 : exp_sat + e.nsat;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {32'b0, bus.out_data}, 64'hDEAD_0000_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    if (!quiet) $display("OUT %0d data=0x%08h exp=0x%08h", n_out, bus.out_data, e.data);
                    check("out_data", {32'b0, bus.out_data}, {32'b0, e.data});
                end
                n_out++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic m, input logic [63:0] a, input logic [63:0] b,
                            input logic [4:0] s, input logic r);
        bus.mode      = m;
        bus.acc_in    = a;
        bus.bias      = b;
        bus.shift     = s;
        bus.relu      = r;
        bus.acc_valid = 1'b1;
    endtask

    task automatic send(input logic m, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] s, input logic r);
        bit ok;
        set_beat(m, a, b, s, r);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            ok = bus.acc_ready;
            tick();
            if (ok) begin
                bus.acc_valid = 1'b0;
                return;
            end
        end
        bus.acc_valid = 1'b0;
        fail_bound("send");
    endtask

    task automatic drain();
        int t = 0;
        bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid) && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) fail_bound("drain");
    endtask

    initial begin
        int   vsat;
        int   out_base;
        int   stall_base;
        bit   done;

        vec[0] = '{1'b1, 64'h0000_0000_0000_0100, 64'h0, 5'd2, 1'b0, 32'h0000_0040, 0, 1'b0};
        vec[1] = '{1'b1, 64'h0000_0000_0000_FFFB, 64'h0, 5'd1, 1'b0, 32'h0000_00FE, 0, 1'b0};
        vec[2] = '{1'b0, 64'h0000_8000_007F_FFFF, 64'h0, 5'd0, 1'b0, 32'h0000_807F, 2, 1'b1};
        vec[3] = '{1'b1, 64'h0000_0000_FF00_0000, 64'h0, 5'd0, 1'b1,
                   RELU_BUILT ? 32'h0000_0000 : 32'h0000_8000, RELU_BUILT ? 0 : 1, 1'b0};
        vec[4] = '{1'b0, 64'hABCD_FFFF_0000_0100, 64'h1234_5678_0010_FFF0, 5'd3, 1'b0,
                   32'h0000_E21E, 0, 1'b0};
        vec[5] = '{1'b1, 64'h8000_7FFF_8000_7FFF, 64'h8000_7FFF_8000_7FFF, 5'd31, 1'b0,
                   32'h0000_0000, 0, 1'b0};
        vec[6] = '{1'b1, 64'hFF7F_FF80_0080_007F, 64'h0, 5'd0, 1'b0, 32'h8080_7F7F, 2, 1'b0};
        vec[7] = '{1'b1, 64'hFFFF_0001_FFFD_0003, 64'h0, 5'd1, 1'b0, 32'h0001_FF02, 0, 1'b0};

        reset = 1'b1;
        stat_clr = 1'b0;
        bus.acc_valid = 1'b0;
        bus.acc_in = '0;
        bus.mode = 1'b0;
        bus.bias = '0;
        bus.shift = '0;
        bus.relu = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        check("rst_out_data", {32'b0, bus.out_data}, 64'd0);
        check("rst_sat_count", {48'b0, sat_count}, 64'd0);
        check("rst_acc_ready", {63'b0, bus.acc_ready}, 64'd1);
        reset = 1'b0;
        tick();

        // Directed vectors: single beat, latency and value checks
        vsat = 0;
        for (int k = 0; k < NV; k++) begin
            set_beat(vec[k].mode, vec[k].acc, vec[k].bias, vec[k].shift, vec[k].relu);
            tick();
            bus.acc_valid = 1'b0;
            tick();
            check("latency_early", {63'b0, bus.out_valid}, 64'd0);
            tick();
            vsat = vsat + vec[k].exp_sat_inc;
            check("vec_valid", {63'b0, bus.out_valid}, 64'd1);
            check("vec_data", {32'b0, bus.out_data}, {32'b0, vec[k].exp_data});
            check("vec_sat", {48'b0, sat_count}, vsat);
            tick();
            if (vec[k].clr_after) begin
                stat_clr = 1'b1;
                tick();
                stat_clr = 1'b0;
                check("stat_clr", {48'b0, sat_count}, 64'd0);
                vsat = 0;
                exp_sat = 0;
            end
        end
        drain();

        // Six back-to-back beats with out_ready low for cycles 4..7
        out_base = n_out;
        stall_base = stall_cycles;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(1'b1, {16'(i * 40), 16'(-i * 3), 16'(i), 16'(i * 300)}, 64'h0, 5'd1, 1'b0);
            end
            begin
                for (int c = 0; c < 16; c++) begin
                    bus.out_ready = !(c >= 4 && c <= 7);
                    tick();
                end
            end
        join
        drain();
        check("stall_count", stall_cycles - stall_base, 64'd4);
        check("stream_count", n_out - out_base, 64'd6);

        // Reset mid-flight: two saturating beats discarded
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        set_beat(1'b1, 64'h7FFF_7FFF_7FFF_7FFF, 64'h0, 5'd0, 1'b0);
        tick();
        set_beat(1'b0, 64'h0000_8000_007F_FFFF, 64'h0, 5'd0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.acc_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("rst_mid_valid", {63'b0, bus.out_valid}, 64'd0);
            tick();
        end
        check("rst_mid_sat", {48'b0, sat_count}, 64'd0);

        // Counter sticks at 0xFFFF
        quiet = 1'b1;
        for (int i = 0; i < 16400; i++)
            send(1'b1, 64'h7FFF_7FFF_7FFF_7FFF, 64'h0, 5'd0, 1'b0);
        drain();
        quiet = 1'b0;
        check("sat_sticky", {48'b0, sat_count}, exp_sat);
        check("sat_sticky_ffff", {48'b0, sat_count}, 64'hFFFF);

        // Clear wins over an increment in the same cycle
        send(1'b1, 64'h7FFF_7FFF_7FFF_7FFF, 64'h0, 5'd0, 1'b0);
        send(1'b1, 64'h7FFF_7FFF_7FFF_7FFF, 64'h0, 5'd0, 1'b0);
        stat_clr = 1'b1;
        send(1'b1, 64'h7FFF_7FFF_7FFF_7FFF, 64'h0, 5'd0, 1'b0);
        stat_clr = 1'b0;
        check("clr_priority", {48'b0, sat_count}, 64'd0);
        drain();
        check("clr_then_count", {48'b0, sat_count}, 64'd8);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        exp_sat = 0;

        // Randomized stream with random backpressure
        out_base = n_out;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    int gap;
                    logic [4:0] sh;
                    gap = $urandom_range(0, 2);
                    for (int g = 0; g < gap; g++) begin
                        bus.acc_in = {$urandom, $urandom};
                        tick();
                    end
                    sh = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 12));
                    send(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom} >> $urandom_range(0, 60),
                         sh, 1'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("rand_count", n_out - out_base, 64'd300);
        check("rand_sat", {48'b0, sat_count}, exp_sat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
